hamming_secded_decoder: RTL and testbench
=========================================

# hamming_secded_decoder

Parametrised, pipelined extended-Hamming (SECDED) decoder for the FSK receive path. Takes one codeword per valid/ready handshake, corrects any single-bit error, and flags double or invalid-syndrome errors. Data is re-emitted on a valid/ready output after two register stages. Saturating error counters feed link-quality monitoring.

## Interface
- DATA_W, 8: payload bits per codeword, 4..57.
- P, derived: smallest integer with 2^P >= DATA_W+P+1. P = 4 for DATA_W = 8.
- N, derived: DATA_W+P. Codeword width is N+1.
- CNT_W, 16: width of each error counter.

Ports:
- clk  in  1  clock. All logic is on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_codeword  in  N+1  received codeword.
- in_valid  in  1  in_codeword is valid.
- in_ready  out  1  block accepts in_codeword this cycle.
- correct_en  in  1  1 = correct single-bit errors; 0 = detect only. Sampled with the word at input handshake.
- out_data  out  DATA_W  decoded payload.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts the output word.
- out_err_single  out  1  single-bit error detected in the word (includes an error on the overall-parity bit).
- out_err_multi  out  1  uncorrectable error detected.
- out_syndrome  out  P  raw Hamming syndrome of the word.
- cnt_clr  in  1  synchronous clear of both counters.
- cnt_single  out  CNT_W  saturating count of words with a single-bit error.
- cnt_multi  out  CNT_W  saturating count of words with an uncorrectable error.

## Operation
- Codeword bit index i holds Hamming position i+1, for i = 0..N-1. Index N holds the overall even-parity bit.
- Check bits sit at power-of-two positions. Data bits occupy the remaining positions 3, 5, 6, 7, 9… in ascending order, with data[0] at the lowest.
- Syndrome s = XOR of (i+1) over all set bits i < N. Parity p = XOR of all N+1 bits.
- Classification:
  - s=0, p=0: clean.
  - s=0, p=1: parity-bit error. Single; data is untouched.
  - s in 1..N, p=1: single error. Invert bit s-1 when correct_en=1.
  - s>N, p=1: multi.
  - s≠0, p=0: multi.
- Multi words are output as raw extracted data, with no correction.
- When correct_en=0, no bit is ever inverted; the error flags are still computed.
- Stage 1 registers the codeword, s, p and correct_en. Stage 2 registers the corrected data, flags and syndrome.
- Counters update on an output handshake (out_valid & out_ready):
  - cnt_single += out_err_single.
  - cnt_multi += out_err_multi.
  - Each counter saturates at 2^CNT_W-1.
- If cnt_clr coincides with an increment, clear wins and the counter is 0 next cycle.

## Timing
- Reset values: out_valid=0, out_data=0, out_err_single=0, out_err_multi=0, out_syndrome=0, cnt_single=0, cnt_multi=0, and both stage-valid bits 0.
- Flow control:
  - s2_load = !out_valid | out_ready.
  - s1_load = !s1_valid | s2_load.
  - in_ready = s1_load. This is combinational from out_ready, with no registered path.
- Latency: 2 cycles from input handshake to out_valid, with out_ready held high.
- Throughput: 1 word per cycle.
- Stall: with out_ready=0, out_data and the flags hold. A second word can be held in stage 1; then in_ready falls to 0.
- No word is dropped or duplicated under any out_ready pattern.
- rst asserted mid-stream flushes both stages; in-flight words are discarded.
- in_ready is 0 in the reset cycle.

## Test plan
- Clean word, DATA_W=8, correct_en=1: send 0x0A27 -> 2 cycles later out_data=0xA5, both flags 0, syndrome 0. Also send 0x0000 -> out_data 0x00.
- Single-bit errors: send 0x0A07 -> out_data=0xA5, single=1, syndrome=6. Send 0x1A27 -> out_data=0xA5, single=1, syndrome=0.
- Uncorrectable errors:
  - Send 0x0A06 -> multi=1, syndrome=7, out_data=0xA5^0x04=0xA1.
  - Send 0x0224 -> multi=1, syndrome=15.
  - After these, cnt_multi=2.
- Detect-only: send 0x0A07 with correct_en=0 -> out_data=0xA1, single=1.
- Backpressure: stream 20 random encoded words with random errors, out_ready toggling pseudo-randomly. Required: output order and content match the reference model, no loss, and in_ready=0 only while both stages are full and out_ready=0.
- Counters:
  - With CNT_W=4, send 20 single-error words -> cnt_single saturates at 15.
  - Assert cnt_clr on the same cycle as an error handshake -> 0 next cycle.
  - Assert rst mid-stream -> out_valid=0 next cycle.

Source files
------------

// File: rtl/hamming_secded_decoder.sv
`default_nettype none
// ============================================================================
// Module   : hamming_secded_decoder
// Purpose  : Two-stage pipelined extended-Hamming (SECDED) decoder with
//            valid/ready flow control and saturating error counters.
// Revision : 1.0 - initial release
// ============================================================================
module hamming_secded_decoder #(
    parameter  int DATA_W = 8,
    parameter  int CNT_W  = 16,
    localparam int P      = (DATA_W <= 4)  ? 3 :
                            (DATA_W <= 11) ? 4 :
                            (DATA_W <= 26) ? 5 : 6,
    localparam int N      = DATA_W + P
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N:0]        in_codeword,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              correct_en,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_err_single,
    output logic              out_err_multi,
    output logic [P-1:0]      out_syndrome,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  cnt_single,
    output logic [CNT_W-1:0]  cnt_multi
);

    // Codeword index holding payload bit j (non-power-of-two positions, ascending).
    function automatic int data_pos(input int j);
        int k;
        int idx;
        k   = 0;
        idx = 0;
        for (int pos = 1; pos <= N; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                if (k == j) idx = pos - 1;
                k++;
            end
        end
        return idx;
    endfunction

    // ------------------------------------------------------------------
    // Flow control
    // ------------------------------------------------------------------
    logic r_s1_valid;
    logic r_out_valid;
    logic w_s2_load;
    logic w_s1_load;
    logic w_in_hs;
    logic w_out_hs;

    assign w_s2_load = ~r_out_valid | out_ready;
    assign w_s1_load = ~r_s1_valid | w_s2_load;
    assign in_ready  = w_s1_load & ~rst;
    assign w_in_hs   = in_valid & in_ready;
    assign w_out_hs  = r_out_valid & out_ready;

    // ------------------------------------------------------------------
    // Stage 1: syndrome, overall parity, raw payload extraction
    // ------------------------------------------------------------------
    logic [P-1:0]      w_syn_in;
    logic              w_par_in;
    logic [DATA_W-1:0] w_raw_in;
    logic [DATA_W-1:0] r_s1_raw;
    logic [P-1:0]      r_s1_syn;
    logic              r_s1_par;
    logic              r_s1_ce;

    always_comb begin
        w_syn_in = '0;
        for (int i = 0; i < N; i++) begin
            if (in_codeword[i]) w_syn_in = w_syn_in ^ P'(i + 1);
        end
    end

    assign w_par_in = ^in_codeword;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
        end else if (w_s1_load) begin
            r_s1_valid <= in_valid;
        end
    end

    // Only payload positions are carried forward; check bits matter solely through s and p.
    always_ff @(posedge clk) begin
        if (w_in_hs) begin
            r_s1_raw <= w_raw_in;
            r_s1_syn <= w_syn_in;
            r_s1_par <= w_par_in;
            r_s1_ce  <= correct_en;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: classification and correction
    // ------------------------------------------------------------------
    logic              w_syn_nz;
    logic              w_syn_in_range;
    logic              w_single;
    logic              w_multi;
    logic              w_flip;
    logic [DATA_W-1:0] w_fixed;

    assign w_syn_nz       = |r_s1_syn;
    assign w_syn_in_range = int'(r_s1_syn) <= N;
    assign w_single       = r_s1_par & w_syn_in_range;
    assign w_multi        = (w_syn_nz & ~r_s1_par) | (r_s1_par & ~w_syn_in_range);
    assign w_flip         = w_single & r_s1_ce;

    for (genvar j = 0; j < DATA_W; j++) begin : g_data
        localparam int c_idx = data_pos(j);
        assign w_raw_in[j] = in_codeword[c_idx];
        assign w_fixed[j]  = r_s1_raw[j] ^ (w_flip & (r_s1_syn == P'(c_idx + 1)));
    end

    logic [DATA_W-1:0] r_out_data;
    logic              r_out_err_single;
    logic              r_out_err_multi;
    logic [P-1:0]      r_out_syndrome;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid      <= 1'b0;
            r_out_data       <= '0;
            r_out_err_single <= 1'b0;
            r_out_err_multi  <= 1'b0;
            r_out_syndrome   <= '0;
        end else if (w_s2_load) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_data       <= w_fixed;
                r_out_err_single <= w_single;
                r_out_err_multi  <= w_multi;
                r_out_syndrome   <= r_s1_syn;
            end
        end
    end

    assign out_valid      = r_out_valid;
    assign out_data       = r_out_data;
    assign out_err_single = r_out_err_single;
    assign out_err_multi  = r_out_err_multi;
    assign out_syndrome   = r_out_syndrome;

    // ------------------------------------------------------------------
    // Saturating error counters; clear takes priority over increment
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] r_cnt_single;
    logic [CNT_W-1:0] r_cnt_multi;

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            r_cnt_single <= '0;
            r_cnt_multi  <= '0;
        end else begin
            if (w_out_hs && r_out_err_single && (r_cnt_single != '1))
                r_cnt_single <= r_cnt_single + CNT_W'(1);
            if (w_out_hs && r_out_err_multi && (r_cnt_multi != '1))
                r_cnt_multi <= r_cnt_multi + CNT_W'(1);
        end
    end

    assign cnt_single = r_cnt_single;
    assign cnt_multi  = r_cnt_multi;

endmodule
`default_nettype wire

// File: tb/tb_hamming_secded_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_hamming_secded_decoder
// Purpose  : Self-checking bench: directed vectors plus random encoded words
//            with injected errors, scored against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hamming_secded_decoder;

    localparam int DATA_W  = 8;
    localparam int CNT_W   = 4;
    localparam int NB      = 13;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk;
    logic              rst;
    logic [NB-1:0]     in_codeword;
    logic              in_valid;
    logic              in_ready;
    logic              correct_en;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_err_single;
    logic              out_err_multi;
    logic [3:0]        out_syndrome;
    logic              cnt_clr;
    logic [CNT_W-1:0]  cnt_single;
    logic [CNT_W-1:0]  cnt_multi;

    hamming_secded_decoder #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_codeword    (in_codeword),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .correct_en     (correct_en),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_err_single (out_err_single),
        .out_err_multi  (out_err_multi),
        .out_syndrome   (out_syndrome),
        .cnt_clr        (cnt_clr),
        .cnt_single     (cnt_single),
        .cnt_multi      (cnt_multi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference helpers: place payload at non-power-of-two positions, solve check bits.
    function automatic logic [NB-1:0] encode(input logic [7:0] d);
        logic [NB-1:0] cw;
        int k;
        int s;
        cw = '0;
        k  = 0;
        s  = 0;
        for (int pos = 1; pos <= 12; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                cw[pos-1] = d[k];
                if (d[k]) s = s ^ pos;
                k++;
            end
        end
        for (int j = 0; j < 4; j++) begin
            if (s[j]) cw[(1 << j) - 1] = 1'b1;
        end
        cw[12] = ^cw[11:0];
        return cw;
    endfunction

    function automatic logic [7:0] extract(input logic [NB-1:0] cw);
        logic [7:0] d;
        int k;
        d = '0;
        k = 0;
        for (int pos = 1; pos <= 12; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                d[k] = cw[pos-1];
                k++;
            end
        end
        return d;
    endfunction

    function automatic int hpos(input int e);
        return (e < 12) ? e + 1 : 0;
    endfunction

    typedef struct {
        logic [7:0] data;
        logic       s;
        logic       m;
        logic [3:0] syn;
        int         cyc;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   m_cnt_s = 0;
    int   m_cnt_m = 0;

    logic [7:0] drv_d;
    logic       drv_s;
    logic       drv_m;
    logic [3:0] drv_syn;
    int         ready_mode = 0;

    // 0: out_ready held high, 1: random, 2: driven manually by the stimulus
    always @(posedge clk) begin
        #1;
        if (ready_mode == 0)      out_ready = 1'b1;
        else if (ready_mode == 1) out_ready = 1'($urandom_range(0, 1));
    end

    // Scoreboard: in-flight words, latency/occupancy expectations, counter model
    always @(negedge clk) begin
        chk("cnt_single", 64'(cnt_single), 64'(m_cnt_s));
        chk("cnt_multi", 64'(cnt_multi), 64'(m_cnt_m));
        if (rst) begin
            chk("in_ready_in_reset", 64'(in_ready), 64'(0));
            q.delete();
            m_cnt_s = 0;
            m_cnt_m = 0;
        end else begin
            chk("in_ready", 64'(in_ready), 64'((q.size() < 2) || out_ready));
            chk("out_valid", 64'(out_valid),
                64'((q.size() > 0) && ((cyc - q[0].cyc) >= 2)));
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("spurious_output", 64'(1), 64'(0));
                end else begin
                    mon_e = q.pop_front();
                    chk("out_data", 64'(out_data), 64'(mon_e.data));
                    chk("err_single", 64'(out_err_single), 64'(mon_e.s));
                    chk("err_multi", 64'(out_err_multi), 64'(mon_e.m));
                    chk("syndrome", 64'(out_syndrome), 64'(mon_e.syn));
                    if (mon_e.s && m_cnt_s < CNT_MAX) m_cnt_s++;
                    if (mon_e.m && m_cnt_m < CNT_MAX) m_cnt_m++;
                end
            end
            if (cnt_clr) begin
                m_cnt_s = 0;
                m_cnt_m = 0;
            end
            if (in_valid && in_ready)
                q.push_back('{data: drv_d, s: drv_s, m: drv_m, syn: drv_syn, cyc: cyc});
        end
        cyc++;
    end

    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [NB-1:0] cw, input logic ce, input logic [7:0] ed,
                        input logic es, input logic em, input logic [3:0] esyn);
        logic acc;
        int   waited;
        in_codeword = cw;
        correct_en  = ce;
        drv_d       = ed;
        drv_s       = es;
        drv_m       = em;
        drv_syn     = esyn;
        in_valid    = 1'b1;
        waited      = 0;
        acc         = 1'b0;
        while (!acc && waited < 100) begin
            @(negedge clk);
            acc = in_ready;
            to_drive();
            waited++;
        end
        if (!acc) chk("send_timeout", 64'(0), 64'(1));
        in_valid = 1'b0;
    endtask

    task automatic send_rand(input int ne);
        logic [7:0]    d;
        logic          ce;
        logic [NB-1:0] cw;
        int            e1;
        int            e2;
        d  = 8'($urandom);
        ce = ($urandom_range(0, 3) != 0);
        cw = encode(d);
        e1 = $urandom_range(0, 12);
        e2 = (e1 + $urandom_range(1, 12)) % 13;
        if (ne == 0) begin
            send(cw, ce, d, 1'b0, 1'b0, 4'd0);
        end else if (ne == 1) begin
            cw[e1] = ~cw[e1];
            send(cw, ce, ce ? d : extract(cw), 1'b1, 1'b0, 4'(hpos(e1)));
        end else begin
            cw[e1] = ~cw[e1];
            cw[e2] = ~cw[e2];
            send(cw, ce, extract(cw), 1'b0, 1'b1, 4'(hpos(e1) ^ hpos(e2)));
        end
    endtask

    // Returns at a negedge once every accepted word has left and counters settled.
    task automatic drain();
        int waited;
        waited = 0;
        in_valid = 1'b0;
        while (q.size() != 0 && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (q.size() != 0) chk("drain_timeout", 64'(q.size()), 64'(0));
        @(negedge clk);
    endtask

    initial begin
        rst         = 1'b1;
        in_codeword = '0;
        in_valid    = 1'b0;
        correct_en  = 1'b1;
        cnt_clr     = 1'b0;
        out_ready   = 1'b1;
        drv_d       = '0;
        drv_s       = 1'b0;
        drv_m       = 1'b0;
        drv_syn     = '0;

        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data", 64'(out_data), 64'(0));
        chk("rst_err_single", 64'(out_err_single), 64'(0));
        chk("rst_err_multi", 64'(out_err_multi), 64'(0));
        chk("rst_syndrome", 64'(out_syndrome), 64'(0));
        repeat (2) @(negedge clk);
        to_drive();
        rst = 1'b0;

        // Directed vectors with hand-derived results
        send(13'h0A27, 1'b1, 8'hA5, 1'b0, 1'b0, 4'd0);
        send(13'h0000, 1'b1, 8'h00, 1'b0, 1'b0, 4'd0);
        send(13'h0A07, 1'b1, 8'hA5, 1'b1, 1'b0, 4'd6);
        send(13'h1A27, 1'b1, 8'hA5, 1'b1, 1'b0, 4'd0);
        send(13'h0A06, 1'b1, 8'hA1, 1'b0, 1'b1, 4'd7);
        send(13'h0224, 1'b1, 8'h25, 1'b0, 1'b1, 4'd15);
        drain();
        chk("cnt_multi_directed", 64'(cnt_multi), 64'(2));
        chk("cnt_single_directed", 64'(cnt_single), 64'(2));
        to_drive();
        send(13'h0A07, 1'b0, 8'hA1, 1'b1, 1'b0, 4'd6);

        // Random words under random backpressure
        ready_mode = 1;
        for (int i = 0; i < 20; i++) send_rand($urandom_range(0, 2));
        drain();
        ready_mode = 0;

        // Saturation of the single-error counter
        to_drive();
        cnt_clr = 1'b1;
        to_drive();
        cnt_clr = 1'b0;
        for (int i = 0; i < 20; i++) send_rand(1);
        drain();
        chk("cnt_single_saturated", 64'(cnt_single), 64'(CNT_MAX));

        // Clear coinciding with an error handshake
        to_drive();
        cnt_clr = 1'b1;
        to_drive();
        cnt_clr = 1'b0;
        send(13'h0A07, 1'b1, 8'hA5, 1'b1, 1'b0, 4'd6);
        drain();
        chk("cnt_single_one", 64'(cnt_single), 64'(1));
        ready_mode = 2;
        to_drive();
        out_ready = 1'b0;
        send(13'h0A07, 1'b1, 8'hA5, 1'b1, 1'b0, 4'd6);
        to_drive();
        out_ready = 1'b1;
        cnt_clr   = 1'b1;
        @(negedge clk);
        chk("clr_handshake_valid", 64'(out_valid), 64'(1));
        to_drive();
        cnt_clr    = 1'b0;
        ready_mode = 0;
        @(negedge clk);
        chk("cnt_clr_wins", 64'(cnt_single), 64'(0));

        // Reset in the middle of a stream
        to_drive();
        send_rand(0);
        send_rand(2);
        rst = 1'b1;
        to_drive();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_flush_out_valid", 64'(out_valid), 64'(0));
        to_drive();
        send_rand(1);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
